// File: rtl/seg_decode_monitor.sv
// Passive checker for the four-digit seven-segment bus: decodes, debounces and validates countdown values.
// Optional step checker is compiled in when SEG_MON_STEP_CHECK_EN is defined.
module seg_decode_monitor #(
   parameter int unsigned STABLE_CYCLES = 2
) (
   input  logic       clk_divide,
   input  logic       rst_n,
   input  logic [6:0] seg,
   input  logic [6:0] seg2,
   input  logic [6:0] seg3,
   input  logic [6:0] seg4,
   output logic [7:0] data,
   output logic [7:0] data2,
   output logic       valid,
   output logic       blank,
   output logic       err_code,
   output logic       err_step,
   output logic [7:0] err_cnt
);

   localparam logic [0:0] S_WAIT  = 1'b0;
   localparam logic [0:0] S_TRACK = 1'b1;

   localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);
   localparam logic [3:0] STABLE_MAX  = 4'(STABLE_CYCLES);

   logic [0:0]  state;
   logic [27:0] s_word;
   logic [3:0]  stab_cnt;

   logic [27:0] bus_word;
   logic        word_same;
   logic        accept;
   logic [6:0]  digit_in [4];
   logic [3:0]  dig_val  [4];
   logic [3:0]  is_digit;
   logic [3:0]  is_blank;
   logic        all_blank;
   logic        legal_word;
   logic        bad_word;
   logic [7:0]  main_val;
   logic [7:0]  country_val;
   logic        step_err;
   logic        count_err;

   // Returns {is_digit, is_blank, value}; anything else on the bus is an illegal glyph.
   function automatic logic [5:0] decode_glyph(input logic [6:0] g);
      case (g)
         7'b0000001: decode_glyph = {2'b10, 4'd0};
         7'b1001111: decode_glyph = {2'b10, 4'd1};
         7'b0010010: decode_glyph = {2'b10, 4'd2};
         7'b0000110: decode_glyph = {2'b10, 4'd3};
         7'b1001100: decode_glyph = {2'b10, 4'd4};
         7'b0100100: decode_glyph = {2'b10, 4'd5};
         7'b0100000: decode_glyph = {2'b10, 4'd6};
         7'b0001111: decode_glyph = {2'b10, 4'd7};
         7'b0000000: decode_glyph = {2'b10, 4'd8};
         7'b0000100: decode_glyph = {2'b10, 4'd9};
         7'b1111111: decode_glyph = {2'b01, 4'd0};
         default:    decode_glyph = {2'b00, 4'd0};
      endcase
   endfunction

   assign digit_in[0] = seg;
   assign digit_in[1] = seg2;
   assign digit_in[2] = seg3;
   assign digit_in[3] = seg4;

   for (genvar i = 0; i < 4; i++) begin : g_dec
      assign {is_digit[i], is_blank[i], dig_val[i]} = decode_glyph(digit_in[i]);
   end

   always_comb begin
      bus_word    = {seg4, seg3, seg2, seg};
      word_same   = (bus_word == s_word);
      accept      = word_same && (stab_cnt == STABLE_LAST);
      all_blank   = &is_blank;
      legal_word  = &is_digit;
      bad_word    = !all_blank && !legal_word;
      main_val    = ({4'd0, dig_val[1]} * 8'd10) + {4'd0, dig_val[0]};
      country_val = ({4'd0, dig_val[3]} * 8'd10) + {4'd0, dig_val[2]};
      count_err   = bad_word || step_err;
   end

`ifdef SEG_MON_STEP_CHECK_EN
   logic err_step_q;
   logic step_main;
   logic step_country;

   // A drop of more than one is a skipped value; a hold or an upward reload is legal.
   always_comb begin
      step_main    = ({1'b0, main_val} + 9'd1) < {1'b0, data};
      step_country = ({1'b0, country_val} + 9'd1) < {1'b0, data2};
      step_err     = (state == S_TRACK) && legal_word && (step_main || step_country);
   end

   always_ff @(posedge clk_divide or posedge rst_n) begin
      if (rst_n) begin
         err_step_q <= 1'b0;
      end else if (accept && step_err) begin
         err_step_q <= 1'b1;
      end
   end

   assign err_step = err_step_q;
`else
   assign step_err = 1'b0;
   assign err_step = 1'b0;
`endif

   // Errored words leave the state alone, so blank tracks S_WAIT exactly.
   assign blank = (state == S_WAIT);

   always_ff @(posedge clk_divide or posedge rst_n) begin
      if (rst_n) begin
         s_word   <= 28'hFFFFFFF;
         stab_cnt <= 4'd0;
         state    <= S_WAIT;
         data     <= 8'd0;
         data2    <= 8'd0;
         valid    <= 1'b0;
         err_code <= 1'b0;
         err_cnt  <= 8'd0;
      end else begin
         s_word <= bus_word;
         valid  <= accept;
         if (!word_same) begin
            stab_cnt <= 4'd0;
         end else if (stab_cnt != STABLE_MAX) begin
            stab_cnt <= stab_cnt + 4'd1;
         end
         if (accept) begin
            if (all_blank) begin
               state <= S_WAIT;
            end else if (bad_word) begin
               err_code <= 1'b1;
            end else begin
               data  <= main_val;
               data2 <= country_val;
               state <= S_TRACK;
            end
            if (count_err && (err_cnt != 8'hFF)) begin
               err_cnt <= err_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg_decode_monitor.sv
// Self-checking bench for seg_decode_monitor: directed scenarios plus a randomized countdown
// stream checked against a word-level reference model. Honours SEG_MON_STEP_CHECK_EN.
module tb_seg_decode_monitor;

   localparam int STABLE = 2;
`ifdef SEG_MON_STEP_CHECK_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic       clk_divide;
   logic       rst_n;
   logic [6:0] seg, seg2, seg3, seg4;
   logic [7:0] data, data2, err_cnt;
   logic       valid, blank, err_code, err_step;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] glyph_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                  7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
   logic [6:0] bad_tab [4] = '{7'b1111110, 7'b0110110, 7'b1010101, 7'b0000011};

   // Reference model state
   logic [27:0] m_last;
   int          m_run;
   bit          m_track;
   int          m_data, m_data2, m_err_cnt;
   bit          m_valid, m_blank, m_err_code, m_err_step;

   seg_decode_monitor #(.STABLE_CYCLES(STABLE)) dut (
      .clk_divide(clk_divide),
      .rst_n(rst_n),
      .seg(seg),
      .seg2(seg2),
      .seg3(seg3),
      .seg4(seg4),
      .data(data),
      .data2(data2),
      .valid(valid),
      .blank(blank),
      .err_code(err_code),
      .err_step(err_step),
      .err_cnt(err_cnt)
   );

   initial begin
      clk_divide = 1'b0;
      forever #5 clk_divide = ~clk_divide;
   end

   function automatic logic [27:0] enc(input int m, input int c);
      enc = {glyph_tab[c / 10], glyph_tab[c % 10], glyph_tab[m / 10], glyph_tab[m % 10]};
   endfunction

   // 0..9 for a digit, 10 for blank, -1 for an illegal pattern
   function automatic int glyph_value(input logic [6:0] g);
      glyph_value = -1;
      if (g == 7'h7F) glyph_value = 10;
      for (int k = 0; k < 10; k++)
         if (glyph_tab[k] == g) glyph_value = k;
   endfunction

   task automatic model_reset();
      m_last = 28'hFFFFFFF; m_run = 1; m_track = 0;
      m_data = 0; m_data2 = 0; m_err_cnt = 0;
      m_valid = 0; m_blank = 1; m_err_code = 0; m_err_step = 0;
   endtask

   task automatic model_accept(input logic [27:0] w);
      int v [4];
      int n_blank, n_ill, nm, nc;
      bit err;
      n_blank = 0; n_ill = 0; err = 0;
      for (int k = 0; k < 4; k++) begin
         v[k] = glyph_value(w[k*7 +: 7]);
         if (v[k] == 10) n_blank++;
         if (v[k] < 0) n_ill++;
      end
      if (n_blank == 4) begin
         m_blank = 1; m_track = 0;
      end else if (n_blank > 0 || n_ill > 0) begin
         m_err_code = 1; err = 1;
      end else begin
         nm = v[1] * 10 + v[0];
         nc = v[3] * 10 + v[2];
         if (STEP_EN && m_track && (nm < m_data - 1 || nc < m_data2 - 1)) begin
            m_err_step = 1; err = 1;
         end
         m_data = nm; m_data2 = nc; m_blank = 0; m_track = 1;
      end
      if (err && m_err_cnt < 255) m_err_cnt++;
   endtask

   // A word is accepted once it has been seen on STABLE+1 consecutive samples.
   task automatic model_edge(input logic [27:0] w);
      if (w == m_last) m_run++;
      else begin
         m_last = w; m_run = 1;
      end
      m_valid = (m_run == STABLE + 1);
      if (m_valid) model_accept(w);
   endtask

   task automatic drive_cycle(input logic [27:0] w);
      seg = w[6:0]; seg2 = w[13:7]; seg3 = w[20:14]; seg4 = w[27:21];
      @(posedge clk_divide);
      model_edge(w);
      #1;
   endtask

   task automatic test_reset();
      n_cmp++; if (data !== 8'd0) begin n_bad++; $display("[TB] FAIL reset_data: got %0d want 0", data); end
      n_cmp++; if (data2 !== 8'd0) begin n_bad++; $display("[TB] FAIL reset_data2: got %0d want 0", data2); end
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b want 0", valid); end
      n_cmp++; if (blank !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_blank: got %b want 1", blank); end
      n_cmp++; if (err_code !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_err_code: got %b want 0", err_code); end
      n_cmp++; if (err_step !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_err_step: got %b want 0", err_step); end
      n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("[TB] FAIL reset_err_cnt: got %0d want 0", err_cnt); end
   endtask

   task automatic test_blank_hold();
      logic exp_v;
      for (int i = 1; i <= 10; i++) begin
         drive_cycle(28'hFFFFFFF);
         exp_v = (i == 2);
         n_cmp++;
         if (valid !== exp_v) begin n_bad++; $display("[TB] FAIL blank_valid edge %0d: got %b want %b", i, valid, exp_v); end
      end
      n_cmp++; if (blank !== 1'b1) begin n_bad++; $display("[TB] FAIL blank_flag: got %b want 1", blank); end
      n_cmp++; if (data !== 8'd0) begin n_bad++; $display("[TB] FAIL blank_data: got %0d want 0", data); end
      n_cmp++; if (err_cnt !== 8'd0 || err_code !== 1'b0) begin
         n_bad++; $display("[TB] FAIL blank_errors: got cnt=%0d code=%b want 0/0", err_cnt, err_code);
      end
   endtask

   task automatic test_count();
      logic exp_v;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(enc(25, 30));
         exp_v = (i == 2);
         n_cmp++;
         if (valid !== exp_v) begin n_bad++; $display("[TB] FAIL count_valid cyc %0d: got %b want %b", i, valid, exp_v); end
      end
      n_cmp++; if (data !== 8'd25) begin n_bad++; $display("[TB] FAIL count_data: got %0d want 25", data); end
      n_cmp++; if (data2 !== 8'd30) begin n_bad++; $display("[TB] FAIL count_data2: got %0d want 30", data2); end
      n_cmp++; if (blank !== 1'b0) begin n_bad++; $display("[TB] FAIL count_blank: got %b want 0", blank); end
   endtask

   task automatic test_step();
      int seq [4] = '{25, 24, 23, 20};
      for (int s = 0; s < 4; s++) begin
         for (int i = 0; i < 3; i++) drive_cycle(enc(seq[s], 30));
         if (s == 2) begin
            n_cmp++;
            if (err_step !== 1'b0) begin n_bad++; $display("[TB] FAIL step_legal: got %b want 0", err_step); end
         end
      end
      n_cmp++; if (err_step !== STEP_EN) begin n_bad++; $display("[TB] FAIL step_err: got %b want %b", err_step, STEP_EN); end
      n_cmp++; if (err_cnt !== (STEP_EN ? 8'd1 : 8'd0)) begin
         n_bad++; $display("[TB] FAIL step_err_cnt: got %0d want %0d", err_cnt, STEP_EN ? 1 : 0);
      end
      n_cmp++; if (data !== 8'd20) begin n_bad++; $display("[TB] FAIL step_data: got %0d want 20", data); end
   endtask

   task automatic test_reload();
      // 20 -> 1 is itself a skip; the 1 -> 99 reload must add nothing.
      for (int i = 0; i < 3; i++) drive_cycle(enc(1, 30));
      for (int i = 0; i < 3; i++) drive_cycle(enc(99, 30));
      n_cmp++; if (data !== 8'd99) begin n_bad++; $display("[TB] FAIL reload_data: got %0d want 99", data); end
      n_cmp++; if (err_cnt !== (STEP_EN ? 8'd2 : 8'd0)) begin
         n_bad++; $display("[TB] FAIL reload_err_cnt: got %0d want %0d", err_cnt, STEP_EN ? 2 : 0);
      end
      n_cmp++; if (err_code !== 1'b0) begin n_bad++; $display("[TB] FAIL reload_err_code: got %b want 0", err_code); end
   endtask

   task automatic test_illegal();
      logic [27:0] w;
      logic exp_v;
      w = enc(99, 30);
      w[6:0] = 7'b1111110;
      for (int i = 0; i < 3; i++) begin
         drive_cycle(w);
         exp_v = (i == 2);
         n_cmp++;
         if (valid !== exp_v) begin n_bad++; $display("[TB] FAIL illegal_valid cyc %0d: got %b want %b", i, valid, exp_v); end
      end
      n_cmp++; if (err_code !== 1'b1) begin n_bad++; $display("[TB] FAIL illegal_err_code: got %b want 1", err_code); end
      n_cmp++; if (data !== 8'd99) begin n_bad++; $display("[TB] FAIL illegal_data: got %0d want 99", data); end
      n_cmp++; if (err_cnt !== (STEP_EN ? 8'd3 : 8'd1)) begin
         n_bad++; $display("[TB] FAIL illegal_err_cnt: got %0d want %0d", err_cnt, STEP_EN ? 3 : 1);
      end
   endtask

   task automatic test_glitch_and_reset();
      int bad_v;
      bad_v = 0;
      for (int i = 0; i < 20; i++) begin
         drive_cycle(enc((i % 2 == 0) ? 98 : 97, 30));
         n_cmp++;
         if (valid !== 1'b0) begin bad_v++; n_bad++; $display("[TB] FAIL glitch_valid cyc %0d: got %b want 0", i, valid); end
      end
      n_cmp++; if (err_cnt !== (STEP_EN ? 8'd3 : 8'd1)) begin
         n_bad++; $display("[TB] FAIL glitch_err_cnt: got %0d want %0d", err_cnt, STEP_EN ? 3 : 1);
      end
      #2 rst_n = 1'b1;
      #1;
      test_reset();
      model_reset();
      @(posedge clk_divide);
      #1 rst_n = 1'b0;
   endtask

   task automatic test_random();
      int gm, gc, r, pos, hold;
      logic [27:0] w;
      gm = 50; gc = 40;
      for (int it = 0; it < 70; it++) begin
         r = $urandom_range(0, 99);
         if (r < 50) begin
            gm = (gm > 0) ? gm - 1 : 99;
            if ($urandom_range(0, 1) == 1) gc = (gc > 0) ? gc - 1 : 99;
         end else if (r >= 62 && r < 72) begin
            gm = (gm >= 3) ? gm - int'($urandom_range(2, 3)) : 99;
         end else if (r >= 72 && r < 80) begin
            gm = $urandom_range(0, 99);
            gc = $urandom_range(0, 99);
         end
         w = enc(gm, gc);
         pos = $urandom_range(0, 3);
         if (r >= 80 && r < 88) w[pos*7 +: 7] = bad_tab[$urandom_range(0, 3)];
         else if (r >= 88 && r < 93) w[pos*7 +: 7] = 7'h7F;
         else if (r >= 93) w = 28'hFFFFFFF;
         hold = $urandom_range(1, 4);
         for (int h = 0; h < hold; h++) begin
            drive_cycle(w);
            n_cmp++; if (valid !== m_valid) begin n_bad++; $display("[TB] FAIL rnd_valid it %0d: got %b want %b", it, valid, m_valid); end
            n_cmp++; if (data !== 8'(m_data)) begin n_bad++; $display("[TB] FAIL rnd_data it %0d: got %0d want %0d", it, data, m_data); end
            n_cmp++; if (data2 !== 8'(m_data2)) begin n_bad++; $display("[TB] FAIL rnd_data2 it %0d: got %0d want %0d", it, data2, m_data2); end
            n_cmp++; if (blank !== m_blank) begin n_bad++; $display("[TB] FAIL rnd_blank it %0d: got %b want %b", it, blank, m_blank); end
            n_cmp++; if (err_code !== m_err_code) begin n_bad++; $display("[TB] FAIL rnd_err_code it %0d: got %b want %b", it, err_code, m_err_code); end
            n_cmp++; if (err_step !== m_err_step) begin n_bad++; $display("[TB] FAIL rnd_err_step it %0d: got %b want %b", it, err_step, m_err_step); end
            n_cmp++; if (err_cnt !== 8'(m_err_cnt)) begin n_bad++; $display("[TB] FAIL rnd_err_cnt it %0d: got %0d want %0d", it, err_cnt, m_err_cnt); end
         end
      end
   endtask

   initial begin
      rst_n = 1'b1;
      seg = 7'h7F; seg2 = 7'h7F; seg3 = 7'h7F; seg4 = 7'h7F;
      model_reset();
      repeat (2) @(posedge clk_divide);
      #1;
      test_reset();
      rst_n = 1'b0;
      test_blank_hold();
      test_count();
      test_step();
      test_reload();
      test_illegal();
      test_glitch_and_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg_decode_monitor.md
# seg_decode_monitor

Passive monitor on the four-digit seven-segment bus of the traffic-light controller. Decodes the main-road (seg, seg2) and country-road (seg3, seg4) segment patterns back into binary counts, filters transient patterns, and checks the decoded counts for illegal glyphs and illegal countdown steps. Sits beside the display driver on the clk_divide domain. Used on-board as a self-check and in simulation as the bus checker.

## Interface
- STABLE_CYCLES, 2, consecutive equal samples required before a bus word is accepted; legal range 1..15.
- clk_divide  in  1  sampling clock; the same clock that drives the display driver.
- rst_n  in  1  reset; asynchronous, active-high.
- seg  in  7  main ones digit, active-low, bit6=a..bit0=g.
- seg2  in  7  main tens digit.
- seg3  in  7  country ones digit.
- seg4  in  7  country tens digit.
- data  out  8  decoded main count, 0..99.
- data2  out  8  decoded country count, 0..99.
- valid  out  1  one-cycle pulse when a new word is accepted.
- blank  out  1  the last accepted word was all-blank.
- err_code  out  1  sticky: an accepted word contained an illegal glyph.
- err_step  out  1  sticky: a countdown skipped a value.
- err_cnt  out  8  saturating count of accept events that raised any error.

## Operation
- Glyph map: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, blank=1111111. Any other pattern is illegal.
- Bus word = {seg4,seg3,seg2,seg} (28 bits), sampled every edge into s_word.
- stab_cnt (4 bit): incremented, saturating at STABLE_CYCLES, when input == s_word; otherwise cleared to 0.
- Accept: the edge where input == s_word and stab_cnt == STABLE_CYCLES-1. Exactly one accept per stable word. A word held indefinitely is not re-accepted.
- FSM states:
  - S_WAIT: after reset or after an all-blank accept.
  - S_TRACK: entered on a legal, non-blank accept.
- On accept:
  - All four digits blank: blank=1, next state S_WAIT, data and data2 unchanged.
  - Any illegal glyph, or a partial blank: err_code=1, err_cnt+1, data and data2 unchanged, state unchanged, step check skipped.
  - Otherwise: data=tens*10+ones (data2 likewise), blank=0, next state S_TRACK. Arithmetic is 4-bit x 10 + 4-bit into 8 bits; the maximum is 99, so no overflow.
- Step check, S_TRACK only, per channel: new < prev-1 raises err_step. new == prev-1, new == prev, and new > prev (reload) are legal.
- If both channels violate on the same accept, err_cnt increments once.
- err_code and err_step clear only on reset. err_cnt saturates at 255.

## Timing
- Reset values: data=0, data2=0, valid=0, blank=1, err_code=0, err_step=0, err_cnt=0, s_word=28'hFFFFFFF, stab_cnt=0, state S_WAIT.
- rst_n asserted mid-operation clears all of the above immediately, with no clock. The first accept after release follows the normal stability rule.
- Latency: a new word first sampled at edge N is accepted at edge N+STABLE_CYCLES. Outputs are registered at that edge; valid is high for the following cycle only.
- A change on any digit before acceptance restarts the count (stab_cnt=0). No accept occurs and no error is flagged.
- err_cnt, err_code, err_step and valid all update on the same accept edge.

## Configuration
- SEG_MON_STEP_CHECK_EN:
  - Defined: step checker and the previous-value compare are compiled in; behaviour as above.
  - Undefined: err_step is tied to 0, step logic is removed, and err_cnt counts only glyph errors.

## Test plan
- Reset, then hold all-blank 10 cycles -> blank=1, valid pulses once at edge 2, data=0, no errors.
- Drive 25/30 (seg=0100100, seg2=0010010, seg3=0000001, seg4=0000110) for 3 cycles -> valid at edge 2, data=25, data2=30, blank=0.
- Step the main count 25,24,23 then jump to 20, each value held 3 cycles -> err_step=1 on the 20 accept, err_cnt=1, data=20.
- Step the main count 1 -> 99 (reload), each value held 3 cycles -> no error, data=99.
- seg=1111110 held 3 cycles -> err_code=1, data unchanged, err_cnt+1.
- Toggle seg every cycle for 20 cycles -> no valid and no error. Then assert rst_n mid-stream -> all outputs return to reset values without a clock.
